// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver; latency rx start edge -> rx_valid is 2+HALF_BIT+9*CLK_PER_BIT+1 clocks.
// Backpressure: byte held on rx_valid until rx_ready; a byte finishing while still held is dropped and sets sticky overrun.
module uart_rx_byte #(
  parameter int unsigned CLK_PER_BIT = 32'd10417,
  parameter int unsigned HALF_BIT    = CLK_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  localparam logic [31:0] BIT_LAST  = 32'(CLK_PER_BIT - 1);
  localparam logic [31:0] HALF_LAST = 32'(HALF_BIT - 1);

  state_t      state, state_nxt;
  logic [31:0] clk_cnt, cnt_nxt;
  logic [2:0]  bit_idx, idx_nxt;
  logic [7:0]  shreg, shreg_nxt;
  logic [7:0]  data_nxt;
  logic        rx_meta, rx_s;
  logic        valid_nxt, ferr_nxt, ovr_nxt, deliver;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      state     <= IDLE;
      clk_cnt   <= 32'd0;
      bit_idx   <= 3'd0;
      shreg     <= 8'h00;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      rx_meta   <= rx;
      rx_s      <= rx_meta;
      state     <= state_nxt;
      clk_cnt   <= cnt_nxt;
      bit_idx   <= idx_nxt;
      shreg     <= shreg_nxt;
      rx_data   <= data_nxt;
      rx_valid  <= valid_nxt;
      frame_err <= ferr_nxt;
      overrun   <= ovr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = clk_cnt + 32'd1;
    idx_nxt   = bit_idx;
    shreg_nxt = shreg;
    deliver   = 1'b0;
    ferr_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_nxt = 32'd0;
        if (!rx_s) state_nxt = START;
      end
      START: begin
        // A start bit that is no longer low at mid-bit is treated as a glitch.
        if (clk_cnt == HALF_LAST) begin
          cnt_nxt   = 32'd0;
          idx_nxt   = 3'd0;
          state_nxt = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (clk_cnt == BIT_LAST) begin
          cnt_nxt   = 32'd0;
          shreg_nxt = {rx_s, shreg[7:1]};
          if (bit_idx == 3'd7) state_nxt = STOP;
          else                 idx_nxt   = bit_idx + 3'd1;
        end
      end
      STOP: begin
        if (clk_cnt == BIT_LAST) begin
          cnt_nxt = 32'd0;
          if (rx_s) begin
            deliver   = 1'b1;
            state_nxt = IDLE;
          end else begin
            ferr_nxt  = 1'b1;
            state_nxt = BREAK;
          end
        end
      end
      BREAK: begin
        // Hold off until the line returns high so a long break cannot look like a start bit.
        cnt_nxt = 32'd0;
        if (rx_s) state_nxt = IDLE;
      end
      default: begin
        cnt_nxt   = 32'd0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    data_nxt  = rx_data;
    valid_nxt = rx_valid;
    ovr_nxt   = overrun;
    if (deliver) begin
      if (!rx_valid || rx_ready) begin
        data_nxt  = shreg;
        valid_nxt = 1'b1;
      end else begin
        ovr_nxt = 1'b1;
      end
    end else if (rx_valid && rx_ready) begin
      valid_nxt = 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Bench for uart_rx_byte with 16 clocks per bit; expected bytes queued at send time, compared on delivery.
module tb_uart_rx_byte;

  logic       clk;
  logic       nrst;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         fe_cycles = 0;
  int         vld_rises = 0;
  logic       vld_d = 1'b0;

  uart_rx_byte #(.CLK_PER_BIT(16), .HALF_BIT(8)) dut (
    .clk      (clk),
    .nrst     (nrst),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Passive observer: accepted bytes, frame_err high cycles, rx_valid rising edges.
  always @(negedge clk) begin
    if (rx_valid === 1'b1 && rx_ready === 1'b1) got_q.push_back(rx_data);
    if (frame_err === 1'b1) fe_cycles++;
    if (rx_valid === 1'b1 && vld_d !== 1'b1) vld_rises++;
    vld_d = rx_valid;
  end

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1 rx = f[i];
      repeat (15) @(posedge clk);
    end
  endtask

  task automatic wait_valid(input int budget, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (rx_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rx_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s: rx_valid=%b after %0d cycles, required 1", name, rx_valid, budget);
    end
  endtask

  task automatic drain();
    @(posedge clk); #1 rx_ready = 1'b1;
    @(posedge clk); #1 rx_ready = 1'b0;
    @(negedge clk);
    got_q.delete();
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_valid: rx_valid=%b required 0", rx_valid);
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0; rx = 1'b1; rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (rx_valid !== 1'b0)  begin errors++; $display("FAIL rst_valid: got %b required 0", rx_valid); end
    checks++; if (rx_data !== 8'h00)  begin errors++; $display("FAIL rst_data: got %h required 00", rx_data); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rst_ferr: got %b required 0", frame_err); end
    checks++; if (overrun !== 1'b0)   begin errors++; $display("FAIL rst_ovr: got %b required 0", overrun); end
    checks++; if (dut.state !== 3'd0) begin errors++; $display("FAIL rst_state: got %0d required 0", dut.state); end
    nrst = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_frame();
    int lat;
    int fe0;
    logic [7:0] e;
    fe0 = fe_cycles;
    rx_ready = 1'b0;
    exp_q.push_back(8'h59);
    lat = 0;
    fork
      send_frame(8'h59, 1'b1);
      begin
        @(posedge clk);
        @(negedge clk);
        while (rx_valid !== 1'b1 && lat < 400) begin
          lat++;
          @(negedge clk);
        end
      end
    join
    checks++;
    if (lat < 154 || lat > 156) begin errors++; $display("FAIL frame_latency: got %0d clocks required 154..156", lat); end
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL frame_valid: got %b required 1", rx_valid); end
    e = exp_q.pop_front();
    checks++; if (rx_data !== e) begin errors++; $display("FAIL frame_data: got %h required %h", rx_data, e); end
    checks++; if (fe_cycles - fe0 != 0) begin errors++; $display("FAIL frame_ferr: got %0d pulses required 0", fe_cycles - fe0); end
    drain();
  endtask

  task automatic test_glitch();
    int fe0;
    int v0;
    fe0 = fe_cycles;
    v0  = vld_rises;
    @(posedge clk); #1 rx = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx = 1'b1;
    repeat (30) @(negedge clk);
    checks++; if (vld_rises != v0) begin errors++; $display("FAIL glitch_valid: got %0d rises required 0", vld_rises - v0); end
    checks++; if (dut.state !== 3'd0) begin errors++; $display("FAIL glitch_state: got %0d required 0", dut.state); end
    checks++; if (fe_cycles != fe0) begin errors++; $display("FAIL glitch_ferr: got %0d required 0", fe_cycles - fe0); end
  endtask

  task automatic test_frame_err();
    int fe0;
    int v0;
    logic [7:0] e;
    fe0 = fe_cycles;
    v0  = vld_rises;
    send_frame(8'h00, 1'b0);
    repeat (40) @(posedge clk);
    @(negedge clk);
    checks++; if (fe_cycles - fe0 != 1) begin errors++; $display("FAIL ferr_pulse: got %0d cycles required 1", fe_cycles - fe0); end
    checks++; if (vld_rises != v0) begin errors++; $display("FAIL ferr_valid: got %0d rises required 0", vld_rises - v0); end
    checks++; if (dut.state !== 3'd4) begin errors++; $display("FAIL ferr_break: got state %0d required 4", dut.state); end
    @(posedge clk); #1 rx = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (dut.state !== 3'd0) begin errors++; $display("FAIL ferr_idle: got state %0d required 0", dut.state); end
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    wait_valid(20, "ferr_next_valid");
    e = exp_q.pop_front();
    checks++; if (rx_data !== e) begin errors++; $display("FAIL ferr_next_data: got %h required %h", rx_data, e); end
    drain();
  endtask

  task automatic test_overrun();
    logic [7:0] e;
    rx_ready = 1'b0;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    wait_valid(20, "ovr_first_valid");
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_early: got %b required 0", overrun); end
    send_frame(8'h3C, 1'b1);
    repeat (4) @(negedge clk);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b required 1", overrun); end
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid: got %b required 1", rx_valid); end
    e = exp_q.pop_front();
    checks++; if (rx_data !== e) begin errors++; $display("FAIL ovr_data: got %h required %h", rx_data, e); end
    drain();
  endtask

  task automatic test_back_to_back();
    int v0;
    int n;
    logic [7:0] e;
    logic [7:0] g;
    v0 = vld_rises;
    @(posedge clk); #1 rx_ready = 1'b1;
    got_q.delete();
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    n = 0;
    while (got_q.size() < 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    checks++; if (got_q.size() != 2) begin errors++; $display("FAIL b2b_count: got %0d accepts required 2", got_q.size()); end
    checks++; if (vld_rises - v0 != 2) begin errors++; $display("FAIL b2b_pulses: got %0d rises required 2", vld_rises - v0); end
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      checks++; if (g !== e) begin errors++; $display("FAIL b2b_data%0d: got %h required %h", i, g, e); end
    end
    @(posedge clk); #1 rx_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int v0;
    logic [7:0] e;
    rx_ready = 1'b0;
    fork
      send_frame(8'hFF, 1'b1);
      begin
        repeat (88) @(posedge clk);
        @(negedge clk);
        nrst = 1'b0;
        #1;
        checks++; if (rx_data !== 8'h00)  begin errors++; $display("FAIL mid_rst_data: got %h required 00", rx_data); end
        checks++; if (overrun !== 1'b0)   begin errors++; $display("FAIL mid_rst_ovr: got %b required 0", overrun); end
        checks++; if (rx_valid !== 1'b0)  begin errors++; $display("FAIL mid_rst_valid: got %b required 0", rx_valid); end
        checks++; if (dut.state !== 3'd0) begin errors++; $display("FAIL mid_rst_state: got %0d required 0", dut.state); end
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        v0 = vld_rises;
      end
    join
    repeat (5) @(negedge clk);
    checks++; if (vld_rises != v0) begin errors++; $display("FAIL mid_partial: got %0d rises required 0", vld_rises - v0); end
    exp_q.push_back(8'hFF);
    send_frame(8'hFF, 1'b1);
    wait_valid(20, "mid_next_valid");
    e = exp_q.pop_front();
    checks++; if (rx_data !== e) begin errors++; $display("FAIL mid_next_data: got %h required %h", rx_data, e); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1ms;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
